// File: rtl/i2s_tx_ctrl.sv
// Stereo I2S transmitter: one-entry sample-pair buffer feeding a 2*SLOT_W-bit frame,
// serialised MSB-first in Philips format from a BCLK half-period tick.
module i2s_tx_ctrl #(
  parameter int DATA_W = 16,
  parameter int SLOT_W = 32
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              tick,
  input  logic              en,
  input  logic [DATA_W-1:0] sample_l,
  input  logic [DATA_W-1:0] sample_r,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              i2s_bclk,
  output logic              i2s_lrck,
  output logic              i2s_sdata,
  output logic              underrun,
  output logic              busy
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int PAD     = SLOT_W - DATA_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(SLOT_W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [FRAME_W-1:0]   r_frame;
  logic [2*DATA_W-1:0]  r_buf;
  logic                 r_buf_full;
  logic                 r_bclk, r_lrck, r_sdata, r_underrun, r_busy;

  logic [CNT_W-1:0]     w_b, w_idx;
  logic [SLOT_W-1:0]    w_slot_l, w_slot_r;
  logic [FRAME_W-1:0]   w_frame_new;
  logic                 w_start, w_fall, w_wrap, w_stop, w_load, w_accept;

  always_comb begin
    w_start     = (r_state == IDLE) && tick && en;
    w_fall      = (r_state == RUN) && tick && r_bclk;
    w_b         = (r_bit_cnt == LAST) ? '0 : r_bit_cnt + 1'b1;
    w_wrap      = w_fall && (w_b == '0);
    w_stop      = w_wrap && !en;
    w_load      = w_wrap && en;
    w_accept    = sample_valid && !r_buf_full;
    // bit b-1 counted from the MSB, expressed as an index from the LSB
    w_idx       = LAST - w_b + 1'b1;
    w_slot_l    = SLOT_W'(r_buf[2*DATA_W-1:DATA_W]) << PAD;
    w_slot_r    = SLOT_W'(r_buf[DATA_W-1:0]) << PAD;
    w_frame_new = r_buf_full ? {w_slot_l, w_slot_r} : '0;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (tick && en) w_state_nxt = RUN;
      RUN:     if (w_stop)     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_bit_cnt  <= LAST;
      r_frame    <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_bclk     <= 1'b0;
      r_lrck     <= 1'b1;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      // a fresh run starts from an all-zero previous frame so b=0 sends 0
      if (w_start) begin
        r_busy  <= 1'b1;
        r_frame <= '0;
      end
      if (r_state == RUN && tick) begin
        if (!r_bclk) begin
          r_bclk <= 1'b1;
        end else if (w_stop) begin
          r_bclk  <= 1'b0;
          r_lrck  <= 1'b1;
          r_sdata <= 1'b0;
          r_busy  <= 1'b0;
        end else begin
          r_bclk    <= 1'b0;
          r_bit_cnt <= w_b;
          r_lrck    <= (w_b >= HALF);
          if (w_wrap) begin
            r_sdata    <= r_frame[0];
            r_frame    <= w_frame_new;
            r_underrun <= !r_buf_full;
          end else begin
            r_sdata <= r_frame[w_idx];
          end
        end
      end
      // load empties a full buffer; no bypass into the frame being loaded
      if (w_load && r_buf_full) begin
        r_buf_full <= 1'b0;
      end else if (w_accept) begin
        r_buf_full <= 1'b1;
        r_buf      <= {sample_l, sample_r};
      end
    end
  end

  assign sample_ready = ~r_buf_full;
  assign i2s_bclk     = r_bclk;
  assign i2s_lrck     = r_lrck;
  assign i2s_sdata    = r_sdata;
  assign underrun     = r_underrun;
  assign busy         = r_busy;

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Bench for i2s_tx_ctrl: a 32-bit-slot and a 16-bit-slot instance, a per-cycle
// behavioural model (tick counting + pair-level frames) plus scenario tasks.
module tb_i2s_tx_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, tick = 1'b0;
  logic [1:0]  en = '0, valid = '0;
  logic [15:0] sl = '0, sr = '0;
  logic a_rdy, a_bclk, a_lrck, a_sd, a_und, a_busy;
  logic b_rdy, b_bclk, b_lrck, b_sd, b_und, b_busy;

  int n_chk = 0, n_err = 0;
  bit mon_en = 1'b0;
  int und_cnt [2];
  bit bp_on = 1'b0;
  logic [15:0] bp_v;

  i2s_tx_ctrl #(.DATA_W(16), .SLOT_W(32)) u_a (
    .clk(clk), .RST(rst), .tick(tick), .en(en[0]), .sample_l(sl), .sample_r(sr),
    .sample_valid(valid[0]), .sample_ready(a_rdy), .i2s_bclk(a_bclk), .i2s_lrck(a_lrck),
    .i2s_sdata(a_sd), .underrun(a_und), .busy(a_busy));

  i2s_tx_ctrl #(.DATA_W(16), .SLOT_W(16)) u_b (
    .clk(clk), .RST(rst), .tick(tick), .en(en[1]), .sample_l(sl), .sample_r(sr),
    .sample_valid(valid[1]), .sample_ready(b_rdy), .i2s_bclk(b_bclk), .i2s_lrck(b_lrck),
    .i2s_sdata(b_sd), .underrun(b_und), .busy(b_busy));

  // reference model: ticks since enable, current/previous frame as sample pairs
  bit          m_run [2], m_full [2], m_und [2], m_plast [2];
  int          m_half [2];
  logic [31:0] m_cur [2], m_buf [2];

  function automatic int slot_of(int i);
    return (i == 0) ? 32 : 16;
  endfunction

  function automatic bit word_bit(int i, logic [31:0] p, int pos);
    int s = slot_of(i);
    if (pos < 16) return p[31-pos];
    if (pos >= s && pos < s + 16) return p[15-(pos-s)];
    return 1'b0;
  endfunction

  function automatic logic [5:0] exp_vec(int i);
    int s = slot_of(i);
    int n, b;
    bit bc, lr, sd;
    if (!m_run[i]) return {1'b0, 1'b1, 1'b0, 1'b0, m_und[i], !m_full[i]};
    bc = m_half[i][0];
    n  = m_half[i] / 2;
    if (n == 0) begin
      lr = 1'b1; sd = 1'b0;
    end else begin
      b  = (n - 1) % (2 * s);
      lr = (b >= s);
      sd = (b == 0) ? m_plast[i] : word_bit(i, m_cur[i], b - 1);
    end
    return {bc, lr, sd, 1'b1, m_und[i], !m_full[i]};
  endfunction

  function automatic logic [5:0] act_vec(int i);
    return (i == 0) ? {a_bclk, a_lrck, a_sd, a_busy, a_und, a_rdy}
                    : {b_bclk, b_lrck, b_sd, b_busy, b_und, b_rdy};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_full[i] = 0; m_und[i] = 0; m_plast[i] = 0;
      m_half[i] = 0; m_cur[i] = '0; m_buf[i] = '0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit acc = valid[i] && !m_full[i];
      int n;
      m_und[i] = 0;
      if (tick) begin
        if (!m_run[i]) begin
          if (en[i]) begin
            m_run[i] = 1; m_half[i] = 0; m_cur[i] = '0; m_plast[i] = 0;
          end
        end else begin
          m_half[i]++;
          n = m_half[i] / 2;
          if (m_half[i] % 2 == 0 && (n - 1) % (2 * slot_of(i)) == 0) begin
            if (!en[i]) m_run[i] = 0;
            else begin
              m_plast[i] = word_bit(i, m_cur[i], 2 * slot_of(i) - 1);
              if (m_full[i]) begin m_cur[i] = m_buf[i]; m_full[i] = 0; end
              else begin m_cur[i] = '0; m_und[i] = 1; end
            end
          end
        end
      end
      if (acc) begin m_buf[i] = {sl, sr}; m_full[i] = 1; end
    end
  endtask

  // inputs change at posedge+1, so at negedge they are what the next edge consumes
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      if (mon_en) begin
        for (int i = 0; i < 2; i++) begin
          n_chk++;
          if (act_vec(i) !== exp_vec(i)) begin
            n_err++;
            $display("FAIL model[%0d] t=%0t: got %b want %b (bclk lrck sdata busy und rdy)",
                     i, $time, act_vec(i), exp_vec(i));
          end
        end
      end
      if (a_und === 1'b1) und_cnt[0]++;
      if (b_und === 1'b1) und_cnt[1]++;
      if (rst) model_reset(); else model_step();
    end
  end

  task automatic cyc();
    bit hs = bp_on && valid[0] && a_rdy;
    @(posedge clk); #1;
    if (hs) begin
      bp_v++;
      sl = bp_v; sr = bp_v + 16'h0100;
    end
  endtask

  task automatic tick_once();
    tick = 1'b1; cyc(); tick = 1'b0;
    repeat ($urandom_range(0, 3)) cyc();
  endtask

  task automatic fall();
    tick_once(); tick_once();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (16) begin
      tick = 1'($urandom); en = 2'($urandom); valid = 2'($urandom);
      sl = 16'($urandom); sr = 16'($urandom);
      cyc();
      n_chk++;
      if ({a_bclk, a_lrck, a_sd, a_rdy, a_busy, a_und, b_bclk, b_lrck, b_sd, b_rdy, b_busy, b_und}
          !== 12'b010100_010100) begin
        n_err++;
        $display("FAIL reset: got %b%b%b%b%b%b_%b%b%b%b%b%b want 010100_010100",
                 a_bclk, a_lrck, a_sd, a_rdy, a_busy, a_und, b_bclk, b_lrck, b_sd, b_rdy, b_busy, b_und);
      end
    end
    tick = 0; en = 0; valid = 0;
    rst = 1'b0; cyc();
    mon_en = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [63:0] got_sd, got_lr;
    logic [63:0] want_sd = {1'b0, 16'hA5A5, 15'h0, 1'b0, 16'h8001, 15'h0};
    logic [63:0] want_lr = {32'h0, 32'hFFFF_FFFF};
    sl = 16'hA5A5; sr = 16'h8001; valid[0] = 1; cyc(); valid[0] = 0;
    n_chk++;
    if (a_rdy !== 1'b0) begin n_err++; $display("FAIL preload_ready: got %b want 0", a_rdy); end
    und_cnt[0] = 0;
    en[0] = 1; tick_once();
    n_chk++;
    if ({a_busy, a_bclk, a_lrck} !== 3'b101) begin
      n_err++; $display("FAIL start: got busy/bclk/lrck %b%b%b want 101", a_busy, a_bclk, a_lrck);
    end
    for (int b = 0; b < 64; b++) begin
      fall();
      got_sd[63-b] = a_sd; got_lr[63-b] = a_lrck;
    end
    for (int b = 0; b < 64; b++) begin
      n_chk++;
      if (got_sd[63-b] !== want_sd[63-b] || got_lr[63-b] !== want_lr[63-b]) begin
        n_err++;
        $display("FAIL frame_bit b=%0d: got sdata=%b lrck=%b want sdata=%b lrck=%b",
                 b, got_sd[63-b], got_lr[63-b], want_sd[63-b], want_lr[63-b]);
      end
    end
    n_chk++;
    if (und_cnt[0] !== 0) begin n_err++; $display("FAIL frame_underrun: got %0d want 0", und_cnt[0]); end
  endtask

  task automatic test_underrun();
    int ones = 0;
    und_cnt[0] = 0;
    for (int k = 0; k < 3 * 64; k++) begin
      fall();
      ones += int'(a_sd);
    end
    n_chk++;
    if (und_cnt[0] !== 3) begin n_err++; $display("FAIL underrun_count: got %0d want 3", und_cnt[0]); end
    n_chk++;
    if (ones !== 0) begin n_err++; $display("FAIL underrun_sdata: got %0d ones want 0", ones); end
  endtask

  task automatic test_stop();
    int toggles = 0;
    logic prev;
    repeat (11) fall();
    en[0] = 0;
    repeat (53) fall();
    n_chk++;
    if ({a_busy, a_lrck} !== 2'b11) begin
      n_err++; $display("FAIL stop_b63: got busy/lrck %b%b want 11", a_busy, a_lrck);
    end
    fall();
    n_chk++;
    if ({a_busy, a_bclk, a_lrck, a_sd} !== 4'b0010) begin
      n_err++; $display("FAIL stop_idle: got busy/bclk/lrck/sdata %b%b%b%b want 0010", a_busy, a_bclk, a_lrck, a_sd);
    end
    prev = a_bclk;
    repeat (6) begin
      tick_once();
      if (a_bclk !== prev) toggles++;
      prev = a_bclk;
    end
    n_chk++;
    if (toggles !== 0 || a_busy !== 1'b0) begin
      n_err++; $display("FAIL stop_quiet: got toggles=%0d busy=%b want 0 0", toggles, a_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] fr;
    bp_v = 16'd1; sl = 16'd1; sr = 16'h0101;
    valid[0] = 1; bp_on = 1;
    cyc();
    n_chk++;
    if (a_rdy !== 1'b0) begin n_err++; $display("FAIL bp_ready_after_accept: got %b want 0", a_rdy); end
    und_cnt[0] = 0;
    en[0] = 1; tick_once();
    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < 64; b++) begin
        fall();
        fr[63-b] = a_sd;
      end
      n_chk++;
      if (fr[62:47] !== 16'(f + 1) || fr[30:15] !== 16'(f + 1 + 256)) begin
        n_err++;
        $display("FAIL bp_frame%0d: got L=%h R=%h want L=%h R=%h", f, fr[62:47], fr[30:15],
                 16'(f + 1), 16'(f + 1 + 256));
      end
    end
    n_chk++;
    if (und_cnt[0] !== 0) begin n_err++; $display("FAIL bp_underrun: got %0d want 0", und_cnt[0]); end
    en[0] = 0;
    for (int k = 0; k < 80 && a_busy; k++) fall();
    bp_on = 0; valid[0] = 0;
    n_chk++;
    if (a_busy !== 1'b0) begin n_err++; $display("FAIL bp_stop: got busy=%b want 0", a_busy); end
  endtask

  task automatic test_mid_reset();
    int ones = 0;
    logic [31:0] fr;
    sl = 16'h1111; sr = 16'h2222; valid[0] = 1; cyc(); valid[0] = 0;
    en[0] = 1; tick_once(); fall();
    sl = 16'h3333; sr = 16'h4444; valid[0] = 1; cyc(); valid[0] = 0;
    repeat (20) fall();
    rst = 1'b1; cyc();
    n_chk++;
    if ({a_bclk, a_lrck, a_sd, a_rdy, a_busy, a_und} !== 6'b010100) begin
      n_err++; $display("FAIL midreset_vals: got %b%b%b%b%b%b want 010100",
                        a_bclk, a_lrck, a_sd, a_rdy, a_busy, a_und);
    end
    rst = 1'b0; cyc();
    und_cnt[0] = 0;
    tick_once();
    repeat (64) begin fall(); ones += int'(a_sd); end
    n_chk++;
    if (und_cnt[0] !== 1 || ones !== 0) begin
      n_err++; $display("FAIL midreset_discard: got und=%0d ones=%0d want 1 0", und_cnt[0], ones);
    end
    en[0] = 0;
    for (int k = 0; k < 80 && a_busy; k++) fall();
    // 16-bit slots: R LSB is delayed into b=0 of the next frame
    sl = 16'hC3C3; sr = 16'h0001; valid[1] = 1; cyc(); valid[1] = 0;
    en[1] = 1; tick_once(); fall();
    valid[1] = 1; cyc(); valid[1] = 0;
    fr[31] = b_sd;
    for (int b = 1; b < 32; b++) begin
      fall();
      fr[31-b] = b_sd;
      if (b == 15 || b == 16) begin
        n_chk++;
        if (b_lrck !== 1'(b == 16)) begin
          n_err++; $display("FAIL slot16_lrck b=%0d: got %b want %b", b, b_lrck, 1'(b == 16));
        end
      end
    end
    n_chk++;
    if (fr !== {1'b0, 16'hC3C3, 15'h0}) begin
      n_err++; $display("FAIL slot16_frame: got %h want %h", fr, {1'b0, 16'hC3C3, 15'h0});
    end
    fall();
    n_chk++;
    if (b_sd !== 1'b1) begin n_err++; $display("FAIL slot16_rlsb_b0: got %b want 1", b_sd); end
    en[1] = 0;
    for (int k = 0; k < 40 && b_busy; k++) fall();
    n_chk++;
    if (b_busy !== 1'b0) begin n_err++; $display("FAIL slot16_stop: got busy=%b want 0", b_busy); end
  endtask

  task automatic test_random();
    en = 2'b11;
    for (int k = 0; k < 3000; k++) begin
      tick = ($urandom_range(0, 2) == 0);
      valid = 2'($urandom) & 2'($urandom);
      sl = 16'($urandom); sr = 16'($urandom);
      if (k == 2000) en = 2'($urandom);
      cyc();
    end
    en = 2'b00; valid = 2'b00;
    for (int k = 0; k < 4000 && (a_busy || b_busy); k++) begin
      tick = ($urandom_range(0, 2) == 0);
      cyc();
    end
    tick = 0; cyc();
    n_chk++;
    if ({a_busy, b_busy} !== 2'b00) begin
      n_err++; $display("FAIL random_drain: got busy=%b%b want 00", a_busy, b_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_underrun();
    test_stop();
    test_back_to_back();
    test_mid_reset();
    test_random();
    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
